// File: rtl/as_pack.sv
// Shared bus constants for the AS Wishbone fabric.
package as_pack;
  localparam int wbdSel = 8;
endpackage

// File: rtl/as_wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant, one IDLE cycle between
// grants, and a per-grant watchdog that pulses err when the slave stops acking.
module as_wb_arbiter #(
  parameter int addr_width     = 64,
  parameter int data_width     = 64,
  parameter int timeout_cycles = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [addr_width-1:0]     m0_addr_i,
  input  logic [data_width-1:0]     m0_dat_i,
  input  logic [as_pack::wbdSel-1:0] m0_sel_i,
  output logic [data_width-1:0]     m0_dat_o,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [addr_width-1:0]     m1_addr_i,
  input  logic [data_width-1:0]     m1_dat_i,
  input  logic [as_pack::wbdSel-1:0] m1_sel_i,
  output logic [data_width-1:0]     m1_dat_o,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [addr_width-1:0]     s_addr_o,
  output logic [data_width-1:0]     s_dat_o,
  output logic [as_pack::wbdSel-1:0] s_sel_o,
  input  logic [data_width-1:0]     s_dat_i,
  input  logic                      s_ack_i,
  output logic [1:0]                gnt_o
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(timeout_cycles - 1);

  state_t     state_r;
  logic       last_q;
  logic [7:0] wd_q;
  logic       m0_err_r;
  logic       m1_err_r;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       strobe_s;
  logic       timeout_s;

  assign gnt0_s    = (state_r == GNT0);
  assign gnt1_s    = (state_r == GNT1);
  assign strobe_s  = (gnt0_s & m0_stb_i) | (gnt1_s & m1_stb_i);
  assign timeout_s = strobe_s & ~s_ack_i & (wd_q == WD_LAST);

  assign gnt_o    = state_r;
  assign m0_ack_o = s_ack_i & gnt0_s;
  assign m1_ack_o = s_ack_i & gnt1_s;
  assign m0_err_o = m0_err_r;
  assign m1_err_o = m1_err_r;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Slave-side mux: follows the granted master, parks at zero when idle.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    case (state_r)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
      end
      default: begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
      end
    endcase
  end

  // Grant FSM, round-robin history, watchdog and registered err pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      last_q   <= 1'b1;
      wd_q     <= 8'd0;
      m0_err_r <= 1'b0;
      m1_err_r <= 1'b0;
    end else begin
      m0_err_r <= timeout_s & gnt0_s;
      m1_err_r <= timeout_s & gnt1_s;

      if ((state_r == IDLE) || s_ack_i || timeout_s) begin
        wd_q <= 8'd0;
      end else if (strobe_s) begin
        wd_q <= wd_q + 8'd1;
      end else begin
        wd_q <= wd_q;
      end

      case (state_r)
        IDLE: begin
          // On contention the master that was not granted last wins.
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_r <= GNT0;
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_r <= GNT1;
            last_q  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) state_r <= IDLE;
          else           state_r <= GNT0;
        end
        GNT1: begin
          if (!m1_cyc_i) state_r <= IDLE;
          else           state_r <= GNT1;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_as_wb_arbiter.sv
// Directed and randomized bench for as_wb_arbiter against a transaction-level
// ownership/watchdog model.
module tb_as_wb_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = as_pack::wbdSel;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          cyc[2];
  logic          stb[2];
  logic          we[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdat[2];
  logic [SW-1:0] sel[2];
  logic [DW-1:0] rdat[2];
  logic          ack[2];
  logic          err[2];
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  as_wb_arbiter #(.addr_width(AW), .data_width(DW), .timeout_cycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_dat_o(rdat[0]), .m0_ack_o(ack[0]),
    .m0_err_o(err[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_dat_o(rdat[1]), .m1_ack_o(ack[1]),
    .m1_err_o(err[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  // Reference model: who owns the bus (-1 = nobody), who was served last,
  // how many unacked strobe cycles the owner has accumulated, pending err.
  int   owner;
  int   last;
  int   wd_cnt;
  logic exp_err[2];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last = 1;
    wd_cnt = 0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
  endtask

  task automatic model_step();
    logic n_err0, n_err1;
    int o;
    n_err0 = 1'b0;
    n_err1 = 1'b0;
    o = owner;
    if (o < 0) begin
      wd_cnt = 0;
      if (cyc[0] && cyc[1]) owner = 1 - last;
      else if (cyc[0])      owner = 0;
      else if (cyc[1])      owner = 1;
      if (owner >= 0) last = owner;
    end else begin
      if (s_ack_i) wd_cnt = 0;
      else if (stb[o]) begin
        if (wd_cnt + 1 == TO) begin
          wd_cnt = 0;
          if (o == 0) n_err0 = 1'b1;
          else        n_err1 = 1'b1;
        end else begin
          wd_cnt++;
        end
      end
      if (!cyc[o]) owner = -1;
    end
    exp_err[0] = n_err0;
    exp_err[1] = n_err1;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e_cyc, e_stb, e_we, e_addr, e_dat, e_sel, e_gnt;
    e_cyc = 64'd0; e_stb = 64'd0; e_we = 64'd0;
    e_addr = 64'd0; e_dat = 64'd0; e_sel = 64'd0;
    e_gnt = (owner == 0) ? 64'd1 : (owner == 1) ? 64'd2 : 64'd0;
    if (owner >= 0) begin
      e_cyc = 64'(cyc[owner]);
      e_stb = 64'(stb[owner]);
      e_we = 64'(we[owner]);
      e_addr = 64'(addr[owner]);
      e_dat = 64'(wdat[owner]);
      e_sel = 64'(sel[owner]);
    end
    check({tag, "/gnt"}, 64'(gnt_o), e_gnt);
    check({tag, "/ack0"}, 64'(ack[0]), 64'(s_ack_i && owner == 0));
    check({tag, "/ack1"}, 64'(ack[1]), 64'(s_ack_i && owner == 1));
    check({tag, "/err0"}, 64'(err[0]), 64'(exp_err[0]));
    check({tag, "/err1"}, 64'(err[1]), 64'(exp_err[1]));
    check({tag, "/s_cyc"}, 64'(s_cyc_o), e_cyc);
    check({tag, "/s_stb"}, 64'(s_stb_o), e_stb);
    check({tag, "/s_we"}, 64'(s_we_o), e_we);
    check({tag, "/s_addr"}, 64'(s_addr_o), e_addr);
    check({tag, "/s_dat"}, 64'(s_dat_o), e_dat);
    check({tag, "/s_sel"}, 64'(s_sel_o), e_sel);
    check({tag, "/rdat0"}, 64'(rdat[0]), 64'(s_dat_i));
    check({tag, "/rdat1"}, 64'(rdat[1]), 64'(s_dat_i));
  endtask

  // Inputs are set at posedge+1; checks at posedge+2; model advances on the edge.
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc[i] = c; stb[i] = s; we[i] = w; addr[i] = a; wdat[i] = d; sel[i] = 8'hFF;
  endtask

  initial begin
    set_m(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    s_ack_i = 1'b0;
    s_dat_i = 64'h1234_5678_9ABC_DEF0;
    model_reset();
    #3;
    check("reset/gnt", 64'(gnt_o), 64'd0);
    check("reset/s_cyc", 64'(s_cyc_o), 64'd0);
    check("reset/s_stb", 64'(s_stb_o), 64'd0);
    check("reset/err0", 64'(err[0]), 64'd0);
    check("reset/err1", 64'(err[1]), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Stray ack while idle
    s_ack_i = 1'b1;
    cycle("stray");
    cycle("stray2");
    check("stray/gnt", 64'(gnt_o), 64'd0);
    s_ack_i = 1'b0;

    // Contention straight after reset: m0, then m1, then m0 again
    set_m(0, 1'b1, 1'b1, 1'b0, 64'h100, 64'h11);
    set_m(1, 1'b1, 1'b1, 1'b1, 64'h200, 64'h22);
    cycle("cont_req");
    check("cont/first", 64'(gnt_o), 64'd1);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cycle("cont_drop0");
    check("cont/idle", 64'(gnt_o), 64'd0);
    cycle("cont_idle");
    check("cont/second", 64'(gnt_o), 64'd2);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle("cont_drop1");
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    cycle("cont_req2");
    check("cont/third", 64'(gnt_o), 64'd1);
    cyc[0] = 1'b0; cyc[1] = 1'b0;
    cycle("cont_end");

    // Single m0 write with ack one cycle after grant
    set_m(0, 1'b1, 1'b1, 1'b1, 64'h10, 64'hA5);
    cycle("wr_req");
    check("wr/gnt", 64'(gnt_o), 64'd1);
    check("wr/s_addr", 64'(s_addr_o), 64'h10);
    check("wr/s_dat", 64'(s_dat_o), 64'hA5);
    s_ack_i = 1'b1;
    #1;
    check("wr/ack0", 64'(ack[0]), 64'd1);
    check("wr/ack1", 64'(ack[1]), 64'd0);
    cycle("wr_ack");
    set_m(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    s_ack_i = 1'b0;
    cycle("wr_end");

    // m1 timeout: err pulse follows the 16th unacked strobe cycle
    set_m(1, 1'b1, 1'b1, 1'b0, 64'h300, 64'h33);
    cycle("to_req");
    for (int k = 1; k <= TO; k++) begin
      check("to/noerr", 64'(err[1]), 64'd0);
      cycle("to_strobe");
    end
    check("to/err1", 64'(err[1]), 64'd1);
    check("to/err0", 64'(err[0]), 64'd0);
    check("to/hold", 64'(gnt_o), 64'd2);
    cycle("to_after");
    check("to/once", 64'(err[1]), 64'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    cycle("to_end");

    // m0 drops cyc in the very cycle its watchdog fires
    set_m(0, 1'b1, 1'b1, 1'b0, 64'h400, 64'h44);
    cycle("tod_req");
    for (int k = 1; k < TO; k++) cycle("tod_strobe");
    cyc[0] = 1'b0;
    cycle("tod_drop");
    check("tod/gnt", 64'(gnt_o), 64'd0);
    check("tod/err0", 64'(err[0]), 64'd1);
    stb[0] = 1'b0;
    cycle("tod_end");

    // Reset asserted mid-grant
    set_m(0, 1'b1, 1'b1, 1'b0, 64'h500, 64'h55);
    cycle("rst_req");
    check("rst/granted", 64'(gnt_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("rst/async_cyc", 64'(s_cyc_o), 64'd0);
    check("rst/async_gnt", 64'(gnt_o), 64'd0);
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cycle("rel_idle");
    check("rel/gnt", 64'(gnt_o), 64'd1);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    cycle("rel_end");

    // Randomized traffic: frequent acks, then rare acks to provoke timeouts
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] & ($urandom_range(0, 7) != 0);
        we[i] = 1'($urandom());
        addr[i] = {$urandom(), $urandom()};
        wdat[i] = {$urandom(), $urandom()};
        sel[i] = SW'($urandom());
      end
      s_dat_i = {$urandom(), $urandom()};
      s_ack_i = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/as_wb_arbiter.md
AS_WB_ARBITER -- requirements
Module: as_wb_arbiter

Interface
REQ-001 Parameter addr_width, default 64, sets the address bus width.
REQ-002 Parameter data_width, default 64, sets the data bus width; the select width is wbdSel from as_pack.
REQ-003 Parameter timeout_cycles, default 16, range 2..255, is the maximum number of granted-strobe cycles without ack.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 m0_cyc_i / m1_cyc_i  in  1  master bus-cycle request.
REQ-007 m0_stb_i / m1_stb_i  in  1  master valid transfer.
REQ-008 m0_we_i / m1_we_i  in  1  master write enable.
REQ-009 m0_addr_i / m1_addr_i  in  addr_width  master address.
REQ-010 m0_dat_i / m1_dat_i  in  data_width  master write data.
REQ-011 m0_sel_i / m1_sel_i  in  wbdSel  master byte selects.
REQ-012 m0_dat_o / m1_dat_o  out  data_width  read data; both are driven from s_dat_i.
REQ-013 m0_ack_o / m1_ack_o  out  1  transfer acknowledge.
REQ-014 m0_err_o / m1_err_o  out  1  timeout error, one-cycle pulse.
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side bus controls.
REQ-016 s_addr_o  out  addr_width;  s_dat_o  out  data_width;  s_sel_o  out  wbdSel.
REQ-017 s_dat_i  in  data_width;  s_ack_i  in  1  slave-side responses.
REQ-018 gnt_o  out  2  one-hot grant status: bit0 = m0, bit1 = m1.

Function
REQ-019 The FSM shall have three states: IDLE, GNT0 and GNT1, with gnt_o = 00 / 01 / 10 respectively.
REQ-020 IDLE shall go to GNTn on the next edge when only mN_cyc_i is high.
REQ-021 IDLE with both cyc_i high shall grant the master not in register last_q (round-robin); last_q shall reset to 1, so m0 wins first.
REQ-022 Entering GNTn shall load last_q <= n.
REQ-023 GNTn shall return to IDLE on the edge where mN_cyc_i is sampled low.
REQ-024 There shall be exactly one IDLE cycle between consecutive grants, including a regrant of the same master.
REQ-025 Grant latency shall be 1 cycle: a request sampled in IDLE gives gnt_o valid in the following cycle.
REQ-026 In GNTn, all s_* outputs shall be combinationally muxed from master n, with s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i.
REQ-027 In IDLE, s_cyc_o and s_stb_o shall be 0, s_we_o shall be 0, and the address, data and select outputs shall be 0.
REQ-028 mN_ack_o shall equal s_ack_i AND granted(n), combinationally; a non-granted master shall never see ack.
REQ-029 An s_ack_i received in IDLE shall be ignored.
REQ-030 Counter wd_q (8 bit) shall increment each cycle that the granted s_stb_o = 1 and s_ack_i = 0.
REQ-031 wd_q shall clear on s_ack_i, on any IDLE cycle, and after a timeout.
REQ-032 When wd_q = timeout_cycles-1 and there is no ack, the granted master's mN_err_o shall be registered high for exactly one cycle, wd_q shall clear, and the grant shall be held until the master drops cyc.
REQ-033 If the master's cyc drops in the same cycle as a timeout fires, the FSM shall go to IDLE and the err pulse shall still be emitted.
REQ-034 m0_err_o and m1_err_o shall never be high together.

Reset
REQ-035 While rst_ni = 0 (asynchronous assertion), the following shall hold: state IDLE, last_q = 1, wd_q = 0, gnt_o = 00, err outputs 0, s_cyc_o = s_stb_o = 0.
REQ-036 Reset asserted mid-transfer shall drop s_cyc_o immediately, without waiting for a clock edge.
REQ-037 After release, the first grant shall need a clock edge with cyc sampled high.

Verification
REQ-038 The bench shall cover single m0 write: m0 cyc/stb/we = 1, addr = 0x10, dat = 0xA5, slave acks 1 cycle later -> gnt_o = 01, s_addr_o = 0x10, m0_ack_o = 1, m1_ack_o = 0.
REQ-039 The bench shall cover simultaneous requests after reset: both cyc rise together -> m0 granted first; m0 drops -> 1 IDLE cycle, then gnt_o = 10; next contention -> m0.
REQ-040 The bench shall cover timeout: m1 strobes and the slave never acks, timeout_cycles = 16 -> m1_err_o pulses once on the 16th strobe cycle; m0_err_o stays 0.
REQ-041 The bench shall cover reset mid-cycle: rst_ni low during GNT0 -> s_cyc_o = 0 and gnt_o = 00 asynchronously; after release, a request gives a grant with 1-cycle latency.
REQ-042 The bench shall cover a stray ack: s_ack_i = 1 in IDLE -> both ack outputs stay 0 and the FSM stays in IDLE.
